// File: rtl/mont_mul_ctrl_pkg.sv
// mont_ctrl_pkg: shared types and constants for the Montgomery multiplier
// sequencer.
//   state_t      FSM state enumeration (binary encoded)
//   ADD_SEL_*    add operand selector codes: bit0 = add B, bit1 = add M
//   add_sel_of   forms the add selector from the datapath's a_bit/q_bit
package mont_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ADD       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_FINAL_SUB = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [1:0] ADD_SEL_NONE = 2'b00;
  localparam logic [1:0] ADD_SEL_B    = 2'b01;
  localparam logic [1:0] ADD_SEL_M    = 2'b10;
  localparam logic [1:0] ADD_SEL_BM   = 2'b11;

  // a_bit selects B, q_bit selects M; both set means add B+M.
  function automatic logic [1:0] add_sel_of(input logic a_bit, input logic q_bit);
    return {q_bit, a_bit};
  endfunction

endpackage

// File: rtl/mont_mul_ctrl_if.sv
// mont_mul_ctrl_if: command and datapath handshake bundle of the Montgomery
// multiplier sequencer.
//   master : command/datapath side; drives start, a_bit, q_bit, sub_borrow
//            (and abort), observes the controller outputs
//   slave  : the controller; drives busy, done, load_en, add_en, add_sel,
//            shift_en, sub_en, commit_sub, iter (and aborted)
// Optional feature macro: MONT_CTRL_ABORT_EN adds abort / aborted.
interface mont_mul_ctrl_if #(
  parameter int N = 16
);
  localparam int CNT_W = $clog2(N);

  logic             start;
  logic             a_bit;
  logic             q_bit;
  logic             sub_borrow;
  logic             busy;
  logic             done;
  logic             load_en;
  logic             add_en;
  logic [1:0]       add_sel;
  logic             shift_en;
  logic             sub_en;
  logic             commit_sub;
  logic [CNT_W-1:0] iter;
`ifdef MONT_CTRL_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
`ifdef MONT_CTRL_ABORT_EN
    output abort,
    input  aborted,
`endif
    output start, a_bit, q_bit, sub_borrow,
    input  busy, done, load_en, add_en, add_sel, shift_en, sub_en,
           commit_sub, iter
  );

  modport slave (
`ifdef MONT_CTRL_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  start, a_bit, q_bit, sub_borrow,
    output busy, done, load_en, add_en, add_sel, shift_en, sub_en,
           commit_sub, iter
  );

endinterface

// File: rtl/mont_mul_ctrl_iter_counter.sv
// mont_iter_counter: iteration index for the Montgomery sequencer.
//   clk   in   clock
//   clr   in   synchronous clear (has priority over inc)
//   inc   in   advance by one; saturates at N-1 (never wraps)
//   cnt   out  current index, CNT_W bits
//   term  out  cnt == N-1
module mont_iter_counter #(
  parameter  int N     = 16,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  assign term = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mont_mul_ctrl.sv
// mont_mul_ctrl: sequencing FSM for the bit-serial Montgomery multiplier
// (C = A*B*R^-1 mod M). A start accepted in IDLE runs LOAD, N x (ADD, SHIFT),
// FINAL_SUB and DONE, one cycle each; done pulses 2N+2 edges after start.
//   clk, resetn  clock and synchronous active-low reset
//   io (slave)   start, a_bit, q_bit, sub_borrow in;
//                busy, done, load_en, add_en, add_sel, shift_en, sub_en,
//                commit_sub, iter out
// Optional feature macro: MONT_CTRL_ABORT_EN adds io.abort / io.aborted;
// abort in any non-IDLE state returns to IDLE with a one-cycle aborted pulse.
module mont_mul_ctrl
  import mont_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           resetn,
  mont_mul_ctrl_if.slave io
);

  localparam int CNT_W = $clog2(N);

  state_t           state;
  state_t           state_nxt;
  logic             busy_r;
  logic             done_r;
  logic             load_r;
  logic             add_r;
  logic             shift_r;
  logic             sub_r;
  logic             abort_hit;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;
  logic [CNT_W-1:0] cnt;

`ifdef MONT_CTRL_ABORT_EN
  logic aborted_r;
  assign abort_hit  = io.abort && (state != ST_IDLE);
  assign io.aborted = aborted_r;
`else
  assign abort_hit = 1'b0;
`endif

  // Counter is cleared as the start is accepted so iter already reads 0 in
  // LOAD; it advances only on the SHIFT->ADD edge.
  assign cnt_clr = !resetn || abort_hit || ((state == ST_IDLE) && io.start);
  assign cnt_inc = resetn && !abort_hit && (state == ST_SHIFT) && !cnt_term;

  mont_iter_counter #(.N(N)) u_iter (
    .clk  (clk),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .term (cnt_term)
  );

  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      state_nxt = io.start ? ST_LOAD : ST_IDLE;
        ST_LOAD:      state_nxt = ST_ADD;
        ST_ADD:       state_nxt = ST_SHIFT;
        ST_SHIFT:     state_nxt = cnt_term ? ST_FINAL_SUB : ST_ADD;
        ST_FINAL_SUB: state_nxt = ST_DONE;
        ST_DONE:      state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Moore outputs are registered from the next state, so they line up with
  // the state register without a decode stage after it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      load_r  <= 1'b0;
      add_r   <= 1'b0;
      shift_r <= 1'b0;
      sub_r   <= 1'b0;
`ifdef MONT_CTRL_ABORT_EN
      aborted_r <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      busy_r  <= (state_nxt != ST_IDLE);
      done_r  <= (state_nxt == ST_DONE);
      load_r  <= (state_nxt == ST_LOAD);
      add_r   <= (state_nxt == ST_ADD);
      shift_r <= (state_nxt == ST_SHIFT);
      sub_r   <= (state_nxt == ST_FINAL_SUB);
`ifdef MONT_CTRL_ABORT_EN
      aborted_r <= abort_hit;
`endif
    end
  end

  assign io.busy       = busy_r;
  assign io.done       = done_r;
  assign io.load_en    = load_r;
  assign io.add_en     = add_r;
  assign io.shift_en   = shift_r;
  assign io.sub_en     = sub_r;
  assign io.add_sel    = add_r ? add_sel_of(io.a_bit, io.q_bit) : ADD_SEL_NONE;
  assign io.commit_sub = sub_r & ~io.sub_borrow;
  assign io.iter       = cnt;

endmodule
